// File: rtl/mem_arbiter_if.sv
// Cache/memory bus bundle for mem_arbiter: both cache-side links plus the shared memory link.
// slave = the arbiter's view; master = the environment (caches + memory) driving it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_data_valid;
    logic              dc_req_data_ready;
    logic [DATA_W-1:0] dc_req_data_bits;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_data_valid;
    logic              mem_req_data_ready;
    logic [DATA_W-1:0] mem_req_data_bits;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    // Handshakes: a transfer happens in a cycle where valid && ready; valid never waits on ready.
    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data_valid, dc_req_data_bits,
        output dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid, mem_req_data_bits,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data_valid, dc_req_data_bits,
        input  dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid, mem_req_data_bits,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache and dcache, one line transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise the dcache always wins.
module mem_arbiter #(
    parameter int BEATS = 4,
    localparam int CNT_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     bus,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_beat_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IC_RD = 2'd1,
        DC_RD = 2'd2,
        DC_WR = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             pick_dc, pick_ic, req_hs;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d; // 1 = dcache owned the last granted transaction

    always_comb begin
        pick_dc      = bus.dc_req_valid && (!bus.ic_req_valid || !last_grant_q);
        last_grant_d = req_hs ? pick_dc : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end
`else
    always_comb pick_dc = bus.dc_req_valid;
`endif

    always_comb begin
        pick_ic = bus.ic_req_valid && !pick_dc;
        req_hs  = (state_q == IDLE) && (pick_ic || pick_dc) && bus.mem_req_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next state; the counter wraps to 0 on the final beat because BEATS is a power of two
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (req_hs) begin
                    if (pick_ic)            state_d = IC_RD;
                    else if (bus.dc_req_rw) state_d = DC_WR;
                    else                    state_d = DC_RD;
                end
            end
            IC_RD, DC_RD: begin
                if (bus.mem_resp_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) state_d = IDLE;
                end
            end
            DC_WR: begin
                if (bus.dc_req_data_valid && bus.mem_req_data_ready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; every valid/ready is forced low while reset is held
    always_comb begin
        bus.ic_req_ready       = 1'b0;
        bus.dc_req_ready       = 1'b0;
        bus.ic_resp_valid      = 1'b0;
        bus.dc_resp_valid      = 1'b0;
        bus.ic_resp_data       = '0;
        bus.dc_resp_data       = '0;
        bus.dc_req_data_ready  = 1'b0;
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_rw         = 1'b0;
        bus.mem_req_addr       = '0;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits  = bus.dc_req_data_bits;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (pick_dc) begin
                        bus.mem_req_valid = 1'b1;
                        bus.mem_req_rw    = bus.dc_req_rw;
                        bus.mem_req_addr  = bus.dc_req_addr;
                        bus.dc_req_ready  = bus.mem_req_ready;
                    end else if (pick_ic) begin
                        bus.mem_req_valid = 1'b1;
                        bus.mem_req_addr  = bus.ic_req_addr;
                        bus.ic_req_ready  = bus.mem_req_ready;
                    end
                end
                IC_RD: begin
                    bus.ic_resp_valid = bus.mem_resp_valid;
                    bus.ic_resp_data  = bus.mem_resp_data;
                end
                DC_RD: begin
                    bus.dc_resp_valid = bus.mem_resp_valid;
                    bus.dc_resp_data  = bus.mem_resp_data;
                end
                DC_WR: begin
                    bus.mem_req_data_valid = bus.dc_req_data_valid;
                    bus.dc_req_data_ready  = bus.mem_req_data_ready;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state    = state_q;
    assign dbg_beat_cnt = beat_cnt_q;
endmodule
